mult_operand_loader: RTL and testbench

Upstream stage of the 2-bit × 3-bit array multiplier. It receives the two operands as one LSB-first serial frame, assembles them in a shift register, and drives the `m`/`q` operand inputs of the first multiplier row. Operands are held stable for a programmable settle time, then a valid/ack handshake tells the consumer that the combinational product is ready to sample.

---
 rtl/mult_pkg.sv | 29 ++
 rtl/loader_settle_counter.sv | 32 +++
 rtl/mult_operand_loader.sv | 153 +++++++++++++++
 tb/tb_mult_operand_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier operand loader.
// Holds the loader FSM state type, default operand widths, the serial frame
// length helper and the default bit-counter width.
// Build option: MULT_LOADER_PARITY_EN appends one even-parity bit to each frame.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StSettle,
    StPresent
  } loader_state_t;

  localparam int unsigned M_W_DEF = 2;
  localparam int unsigned Q_W_DEF = 3;

  // Serial frame length: operand bits, plus a trailing parity bit when enabled.
  function automatic int unsigned frame_len(input int unsigned m_w, input int unsigned q_w);
`ifdef MULT_LOADER_PARITY_EN
    return m_w + q_w + 1;
`else
    return m_w + q_w;
`endif
  endfunction

  localparam int unsigned FRAME_LEN_DEF = frame_len(M_W_DEF, Q_W_DEF);
  localparam int unsigned BIT_CNT_W     = $clog2(FRAME_LEN_DEF + 1);

endpackage

// File: rtl/loader_settle_counter.sv
// Loadable down-counter that times how long operands are held before they are
// declared valid. Counts down to zero and then rests there.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val this cycle (takes priority over counting)
//   load_val    value to load
//   expire      count is zero
module loader_settle_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/mult_operand_loader.sv
// Serial operand loader feeding the first row of the array multiplier.
// An LSB-first frame is shifted into an operand register whose low M_W bits
// drive m_out and upper Q_W bits drive q_out. After the last bit the operands
// are held for SETTLE_CYCLES cycles, then op_valid is raised until op_ack.
// Build option: MULT_LOADER_PARITY_EN adds a trailing even-parity bit and the
// frame_err output; a parity mismatch pulses frame_err and drops the frame.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle pulse beginning (or restarting) a frame
//   ser_valid, ser_bit   serial input bit and its qualifier
//   ser_ready            a bit is accepted this cycle if ser_valid is high
//   m_out, q_out         operands to the array
//   op_valid, op_ack     product-ready handshake
//   busy                 loader is not idle
//   frame_err            parity error pulse (parity build only)
module mult_operand_loader
  import mult_pkg::*;
#(
  parameter int unsigned M_W           = M_W_DEF,
  parameter int unsigned Q_W           = Q_W_DEF,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           ser_valid,
  input  logic           ser_bit,
  output logic           ser_ready,
  output logic [M_W-1:0] m_out,
  output logic [Q_W-1:0] q_out,
  output logic           op_valid,
  input  logic           op_ack,
  output logic           busy
`ifdef MULT_LOADER_PARITY_EN
  ,
  output logic           frame_err
`endif
);

  localparam int unsigned OP_W  = M_W + Q_W;
  localparam int unsigned FLEN  = frame_len(M_W, Q_W);
  localparam int unsigned CNT_W = $clog2(FLEN + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

`ifdef MULT_LOADER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  loader_state_t    state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [OP_W-1:0]  op_q;

  logic accept;
  logic last;
  logic par_err;
  logic settle_load;
  logic settle_expire;

  // ser_ready is high exactly in SHIFT; a start in SHIFT restarts and wins over a bit.
  assign accept      = ser_valid & ser_ready & ~start;
  assign last        = (bit_cnt_q == CNT_W'(FLEN - 1));
  // Evaluated on the parity-bit accept: operand bits plus parity must be even.
  assign par_err     = PARITY_EN & ((^op_q) ^ ser_bit);
  assign settle_load = accept & last & ~par_err;

  loader_settle_counter #(
    .W(SET_W)
  ) u_settle (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (settle_load),
    .load_val(SET_W'(SETTLE_CYCLES - 1)),
    .expire  (settle_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      op_q      <= '0;
      ser_ready <= 1'b0;
      op_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StShift;
            bit_cnt_q <= '0;
            ser_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StShift: begin
          if (start) begin
            bit_cnt_q <= '0;
          end else if (accept) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            // The trailing parity bit is checked, not stored.
            if (!(PARITY_EN && last)) begin
              op_q <= {ser_bit, op_q[OP_W-1:1]};
            end
            if (last) begin
              ser_ready <= 1'b0;
              if (par_err) begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end else begin
                state_q <= StSettle;
              end
            end
          end
        end
        StSettle: begin
          if (settle_expire) begin
            state_q  <= StPresent;
            op_valid <= 1'b1;
          end
        end
        StPresent: begin
          if (op_ack) begin
            state_q  <= StIdle;
            op_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef MULT_LOADER_PARITY_EN
  logic frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= accept & last & par_err;
    end
  end

  assign frame_err = frame_err_q;
`endif

  assign m_out = op_q[M_W-1:0];
  assign q_out = op_q[OP_W-1:M_W];

endmodule

// File: tb/tb_mult_operand_loader.sv
// Self-checking bench for mult_operand_loader: directed scenarios plus random
// frames, compared against expectations derived from frame contents and cycle
// timing.
module tb_mult_operand_loader;

  localparam int unsigned M_W    = 2;
  localparam int unsigned Q_W    = 3;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned OP_W   = M_W + Q_W;
`ifdef MULT_LOADER_PARITY_EN
  localparam int unsigned FLEN = OP_W + 1;
`else
  localparam int unsigned FLEN = OP_W;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           ser_valid = 1'b0;
  logic           ser_bit = 1'b0;
  logic           ser_ready;
  logic [M_W-1:0] m_out;
  logic [Q_W-1:0] q_out;
  logic           op_valid;
  logic           op_ack = 1'b0;
  logic           busy;
`ifdef MULT_LOADER_PARITY_EN
  logic           frame_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  mult_operand_loader #(
    .M_W          (M_W),
    .Q_W          (Q_W),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ser_valid(ser_valid),
    .ser_bit  (ser_bit),
    .ser_ready(ser_ready),
    .m_out    (m_out),
    .q_out    (q_out),
    .op_valid (op_valid),
    .op_ack   (op_ack),
    .busy     (busy)
`ifdef MULT_LOADER_PARITY_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_err(input logic [31:0] exp);
`ifdef MULT_LOADER_PARITY_EN
    check("frame_err", 32'(frame_err), exp);
`else
    if (exp != 0) check("frame_err_unexpected", 32'(0), exp);
`endif
  endtask

  // Operand value of a frame: bit i of the frame carries weight 2^i.
  function automatic logic [31:0] exp_m(input logic [7:0] fb);
    logic [31:0] v = 0;
    for (int i = 0; i < int'(M_W); i++) if (fb[i]) v = v + (32'd1 << i);
    return v;
  endfunction

  function automatic logic [31:0] exp_q(input logic [7:0] fb);
    logic [31:0] v = 0;
    for (int i = 0; i < int'(Q_W); i++) if (fb[int'(M_W) + i]) v = v + (32'd1 << i);
    return v;
  endfunction

  // Builds a frame from operand bits; in the parity build appends the even
  // parity bit, inverted when bad is set.
  function automatic logic [7:0] mk_frame(input logic [7:0] ops, input bit bad);
    int ones = 0;
    logic [7:0] fb = ops;
    for (int i = 0; i < int'(OP_W); i++) if (ops[i]) ones++;
`ifdef MULT_LOADER_PARITY_EN
    fb[OP_W] = ((ones % 2) == 1) ^ bad;
`endif
    return fb;
  endfunction

  task automatic shift_bits(input logic [7:0] fb, input int n);
    for (int i = 0; i < n; i++) begin
      ser_valid = 1'b1;
      ser_bit   = fb[i];
      tick();
      ser_valid = 1'b0;
    end
  endtask

  // Full frame: start pulse, bits (optionally gapped), settle timing, present
  // window with ack delay and ignored start pulses, then ack.
  task automatic run_frame(input logic [7:0] fb, input int gap_pct, input int ack_delay,
                           input bit start_in_present, input bit expect_ok);
    logic [31:0] em, eq;
    em = exp_m(fb);
    eq = exp_q(fb);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ser_ready_after_start", 32'(ser_ready), 1);
    check("busy_after_start", 32'(busy), 1);
    for (int i = 0; i < int'(FLEN); i++) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        ser_valid = 1'b0;
        ser_bit   = 1'($urandom);
        tick();
        check("ser_ready_gap", 32'(ser_ready), 1);
      end
      ser_valid = 1'b1;
      ser_bit   = fb[i];
      tick();
      ser_valid = 1'b0;
      if (i < int'(FLEN) - 1) begin
        check("ser_ready_shift", 32'(ser_ready), 1);
        check("op_valid_shift", 32'(op_valid), 0);
      end
    end
    check("ser_ready_done", 32'(ser_ready), 0);
    if (!expect_ok) begin
      check_err(1);
      check("busy_after_err", 32'(busy), 0);
      check("m_after_err", 32'(m_out), em);
      check("q_after_err", 32'(q_out), eq);
      for (int c = 0; c < int'(SETTLE) + 3; c++) begin
        tick();
        check_err(0);
        check("op_valid_after_err", 32'(op_valid), 0);
      end
      return;
    end
    check_err(0);
    for (int c = 0; c < int'(SETTLE); c++) begin
      check("op_valid_settle", 32'(op_valid), 0);
      check("busy_settle", 32'(busy), 1);
      tick();
    end
    check("op_valid_rise", 32'(op_valid), 1);
    check("m_out", 32'(m_out), em);
    check("q_out", 32'(q_out), eq);
    for (int d = 0; d < ack_delay; d++) begin
      if (start_in_present && (d % 3 == 0)) start = 1'b1;
      tick();
      start = 1'b0;
      check("op_valid_hold", 32'(op_valid), 1);
      check("ser_ready_hold", 32'(ser_ready), 0);
      check("m_hold", 32'(m_out), em);
      check("q_hold", 32'(q_out), eq);
    end
    op_ack = 1'b1;
    start  = start_in_present;
    tick();
    op_ack = 1'b0;
    start  = 1'b0;
    check("op_valid_after_ack", 32'(op_valid), 0);
    check("busy_after_ack", 32'(busy), 0);
    check("m_after_ack", 32'(m_out), em);
    check("q_after_ack", 32'(q_out), eq);
    tick();
    check("busy_idle", 32'(busy), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_m"}, 32'(m_out), 0);
    check({tag, "_q"}, 32'(q_out), 0);
    check({tag, "_ser_ready"}, 32'(ser_ready), 0);
    check({tag, "_op_valid"}, 32'(op_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check_err(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] fb;
    logic [7:0] ops;
    bit bad;

    #12;
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();
    check_reset_values("post_reset");

    // Frame 1,1,1,0,1 -> m = 2'b11, q = 3'b101.
    fb = mk_frame(8'b10111, 1'b0);
    run_frame(fb, 0, 0, 1'b0, 1'b1);
    check("dir_m", 32'(m_out), 32'b11);
    check("dir_q", 32'(q_out), 32'b101);

    // Gapped: a bubble before every bit.
    run_frame(fb, 100, 1, 1'b0, 1'b1);

    // Restart after 3 accepted bits, then frame 0,1,1,1,0 -> m = 2'b10, q = 3'b011.
    start = 1'b1;
    tick();
    start = 1'b0;
    shift_bits(8'b00100, 3);
    check("op_valid_partial", 32'(op_valid), 0);
    fb = mk_frame(8'b01110, 1'b0);
    run_frame(fb, 0, 2, 1'b0, 1'b1);
    check("restart_m", 32'(m_out), 32'b10);
    check("restart_q", 32'(q_out), 32'b011);

    // Reset during SETTLE clears everything immediately.
    start = 1'b1;
    tick();
    start = 1'b0;
    shift_bits(mk_frame(8'b11011, 1'b0), FLEN);
    check("in_settle_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("settle_reset");
    tick();
    rst_n = 1'b1;
    tick();
    run_frame(mk_frame(8'b01001, 1'b0), 30, 0, 1'b0, 1'b1);

    // Long present window with start pulses that must be ignored.
    run_frame(mk_frame(8'b10010, 1'b0), 0, 10, 1'b1, 1'b1);

`ifdef MULT_LOADER_PARITY_EN
    // Frame 1,0,0,0,0 with parity 0 is bad; with parity 1 it is good.
    run_frame(mk_frame(8'b00001, 1'b1), 0, 0, 1'b0, 1'b0);
    run_frame(mk_frame(8'b00001, 1'b0), 0, 0, 1'b0, 1'b1);
    check("parity_m", 32'(m_out), 32'b01);
`endif

    for (int n = 0; n < 24; n++) begin
      ops = 8'($urandom) & 8'((1 << OP_W) - 1);
`ifdef MULT_LOADER_PARITY_EN
      bad = ($urandom_range(3) == 0);
`else
      bad = 1'b0;
`endif
      run_frame(mk_frame(ops, bad), int'($urandom_range(60)), int'($urandom_range(4)),
                1'($urandom), !bad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
